// File: rtl/pix_frame_unpacker.sv
// Pixel frame unpacker: pops address/data words from a readout FIFO,
// tracks the address sequence and writes complete frames into a frame RAM.
module pix_frame_unpacker #(
  parameter int NPIX = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_cnt,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [5:0]  ram_din,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        seq_err,
  output logic [15:0] err_cnt,
  output logic        synced
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } state_t;

  localparam logic [9:0]  LAST = 10'(NPIX - 1);
  localparam logic [10:0] LIM  = 11'(NPIX);

  state_t     state;
  logic       rd_vld;
  logic [9:0] exp_addr;
  logic [9:0] addr;
  logic [5:0] data;
  logic       in_range;
  logic       match;

  assign addr       = fifo_dout[15:6];
  assign data       = fifo_dout[5:0];
  assign in_range   = {1'b0, addr} < LIM;
  assign match      = in_range && (addr == exp_addr);
  assign fifo_rd_en = en & ~fifo_empty & (state != IDLE);
  assign synced     = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_vld     <= 1'b0;
      exp_addr   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      rd_vld     <= fifo_rd_en;
      unique case (state)
        IDLE: begin
          if (en) state <= SYNC;
        end
        SYNC: begin
          if (!en && !rd_vld) begin
            state    <= IDLE;
            exp_addr <= '0;
          end else if (rd_vld && addr == 10'd0) begin
            ram_we   <= 1'b1;
            ram_addr <= addr;
            ram_din  <= data;
            exp_addr <= 10'd1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!en && !rd_vld) begin
            state    <= IDLE;
            exp_addr <= '0;
          end else if (rd_vld) begin
            if (match) begin
              ram_we   <= 1'b1;
              ram_addr <= addr;
              ram_din  <= data;
              if (addr == LAST) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                exp_addr   <= '0;
              end else begin
                exp_addr <= exp_addr + 10'd1;
              end
            end else begin
              seq_err <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              // An unexpected address 0 restarts the frame in place.
              if (addr == 10'd0) begin
                ram_we   <= 1'b1;
                ram_addr <= addr;
                ram_din  <= data;
                exp_addr <= 10'd1;
              end else begin
                state <= SYNC;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (clr_cnt) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pix_frame_unpacker.sv
// Directed testbench for pix_frame_unpacker with a behavioural FIFO
// and a write monitor.
module tb_pix_frame_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [5:0]  ram_din;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        seq_err;
  logic [15:0] err_cnt;
  logic        synced;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:131071];
  int   rp = 0;
  int   wp = 0;
  logic toggle = 1'b0;
  logic phase = 1'b0;
  logic bvld = 1'b0;
  int   pop_n = 0;

  int wr_n = 0, fd_n = 0, se_n = 0, bad_n = 0, ord_n = 0, early_n = 0;
  int nxt = 0;
  int last_addr = 0, last_din = 0, fd_addr = 0;

  pix_frame_unpacker #(.NPIX(1024)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .seq_err(seq_err), .err_cnt(err_cnt), .synced(synced)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rp == wp) | (toggle & phase);

  always @(posedge clk) begin
    bvld <= fifo_rd_en;
    if (fifo_rd_en) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 1;
      pop_n     <= pop_n + 1;
    end
  end

  always @(negedge clk) begin
    phase <= ~phase;
    if (ram_we) begin
      wr_n = wr_n + 1;
      last_addr = int'(ram_addr);
      last_din  = int'(ram_din);
      if (ram_din != ram_addr[5:0]) bad_n = bad_n + 1;
      if (ram_addr == 10'd0) nxt = 1;
      else begin
        if (int'(ram_addr) != nxt) ord_n = ord_n + 1;
        nxt = (ram_addr == 10'd1023) ? 0 : int'(ram_addr) + 1;
      end
      if (wr_n > pop_n) early_n = early_n + 1;
    end
    if (frame_done) begin
      fd_n = fd_n + 1;
      fd_addr = int'(ram_addr);
    end
    if (seq_err) se_n = se_n + 1;
  end

  task automatic push(input int a);
    mem[wp] = {a[9:0], a[5:0]};
    wp = wp + 1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(i);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (rp != wp && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rp != wp) begin
      errors++;
      $display("FAIL drain: %0d words left, need 0", wp - rp);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: %b need 0", ram_we); end
    if (ram_addr !== 10'd0) begin errors++; $display("FAIL rst_addr: %0d need 0", ram_addr); end
    if (ram_din !== 6'd0) begin errors++; $display("FAIL rst_din: %0d need 0", ram_din); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: %b need 0", frame_done); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_se: %b need 0", seq_err); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_fcnt: %0d need 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_ecnt: %0d need 0", err_cnt); end
    if (synced !== 1'b0) begin errors++; $display("FAIL rst_synced: %b need 0", synced); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd: %b need 0", fifo_rd_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_frame;
    int w0, f0;
    w0 = wr_n; f0 = fd_n;
    push_range(0, 1023);
    en = 1'b1;
    drain(5000);
    checks += 8;
    if (wr_n - w0 != 1024) begin errors++; $display("FAIL ff_writes: %0d need 1024", wr_n - w0); end
    if (fd_n - f0 != 1) begin errors++; $display("FAIL ff_done: %0d need 1", fd_n - f0); end
    if (fd_addr != 1023) begin errors++; $display("FAIL ff_done_addr: %0d need 1023", fd_addr); end
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ff_fcnt: %0d need 1", frame_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL ff_ecnt: %0d need 0", err_cnt); end
    if (bad_n != 0) begin errors++; $display("FAIL ff_data: %0d bad need 0", bad_n); end
    if (ord_n != 0) begin errors++; $display("FAIL ff_order: %0d bad need 0", ord_n); end
    if (synced !== 1'b1) begin errors++; $display("FAIL ff_synced: %b need 1", synced); end
  endtask

  task automatic test_sync_search;
    int w0, p0, s0, n, pre;
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (synced !== 1'b0) begin errors++; $display("FAIL dis_synced: %b need 0", synced); end
    push_range(500, 1023);
    push_range(0, 1023);
    p0 = pop_n;
    repeat (5) @(negedge clk);
    checks++;
    if (pop_n != p0) begin errors++; $display("FAIL dis_pop: %0d pops need 0", pop_n - p0); end
    w0 = wr_n; s0 = se_n; pre = 0; n = 0;
    en = 1'b1;
    while (!ram_we && n < 3000) begin
      if (synced) pre++;
      @(negedge clk);
      n++;
    end
    checks += 3;
    if (pre != 0) begin errors++; $display("FAIL ss_early_sync: %0d need 0", pre); end
    if (ram_addr !== 10'd0 || ram_we !== 1'b1) begin
      errors++; $display("FAIL ss_first: we=%b addr=%0d need we=1 addr=0", ram_we, ram_addr);
    end
    if (synced !== 1'b1) begin errors++; $display("FAIL ss_synced: %b need 1", synced); end
    drain(5000);
    checks += 4;
    if (wr_n - w0 != 1024) begin errors++; $display("FAIL ss_writes: %0d need 1024", wr_n - w0); end
    if (pop_n - p0 - (wr_n - w0) != 524) begin
      errors++; $display("FAIL ss_discard: %0d need 524", pop_n - p0 - (wr_n - w0));
    end
    if (se_n != s0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL ss_err: pulses=%0d cnt=%0d need 0", se_n - s0, err_cnt);
    end
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL ss_fcnt: %0d need 2", frame_cnt); end
  endtask

  task automatic test_seq_error;
    int w0, s0;
    w0 = wr_n; s0 = se_n;
    push_range(0, 9);
    push(12);
    drain(200);
    checks += 4;
    if (se_n - s0 != 1) begin errors++; $display("FAIL se_pulse: %0d need 1", se_n - s0); end
    if (err_cnt !== 16'd1) begin errors++; $display("FAIL se_cnt: %0d need 1", err_cnt); end
    if (wr_n - w0 != 10) begin errors++; $display("FAIL se_writes: %0d need 10", wr_n - w0); end
    if (synced !== 1'b0) begin errors++; $display("FAIL se_sync: %b need 0", synced); end
    push(13); push(14);
    push_range(0, 2);
    drain(200);
    checks += 3;
    if (wr_n - w0 != 13) begin errors++; $display("FAIL se_resync_wr: %0d need 13", wr_n - w0); end
    if (synced !== 1'b1) begin errors++; $display("FAIL se_resync: %b need 1", synced); end
    if (se_n - s0 != 1) begin errors++; $display("FAIL se_resync_err: %0d need 1", se_n - s0); end
  endtask

  task automatic test_restart;
    int w0, s0;
    push_range(3, 299);
    drain(2000);
    w0 = wr_n; s0 = se_n;
    push(0); push(1);
    drain(200);
    checks += 5;
    if (se_n - s0 != 1) begin errors++; $display("FAIL rs_pulse: %0d need 1", se_n - s0); end
    if (err_cnt !== 16'd2) begin errors++; $display("FAIL rs_ecnt: %0d need 2", err_cnt); end
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL rs_fcnt: %0d need 2", frame_cnt); end
    if (wr_n - w0 != 2) begin errors++; $display("FAIL rs_writes: %0d need 2", wr_n - w0); end
    if (last_addr != 1 || synced !== 1'b1) begin
      errors++; $display("FAIL rs_last: addr=%0d synced=%b need 1 1", last_addr, synced);
    end
  endtask

  task automatic test_gap;
    int w0, f0;
    push_range(2, 1023);
    drain(5000);
    w0 = wr_n; f0 = fd_n;
    toggle = 1'b1;
    push_range(0, 1023);
    drain(8000);
    toggle = 1'b0;
    checks += 7;
    if (wr_n - w0 != 1024) begin errors++; $display("FAIL gap_writes: %0d need 1024", wr_n - w0); end
    if (fd_n - f0 != 1) begin errors++; $display("FAIL gap_done: %0d need 1", fd_n - f0); end
    if (fd_addr != 1023) begin errors++; $display("FAIL gap_done_addr: %0d need 1023", fd_addr); end
    if (frame_cnt !== 16'd4) begin errors++; $display("FAIL gap_fcnt: %0d need 4", frame_cnt); end
    if (bad_n != 0 || ord_n != 0) begin
      errors++; $display("FAIL gap_seq: bad=%0d ord=%0d need 0 0", bad_n, ord_n);
    end
    if (early_n != 0) begin errors++; $display("FAIL gap_nopop: %0d need 0", early_n); end
    if (err_cnt !== 16'd2) begin errors++; $display("FAIL gap_ecnt: %0d need 2", err_cnt); end
  endtask

  task automatic test_err_sat;
    int s0;
    s0 = se_n;
    for (int i = 0; i < 65534; i++) push(0);
    drain(70000);
    checks += 2;
    if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: %h need ffff", err_cnt); end
    if (se_n - s0 != 65533) begin errors++; $display("FAIL sat_pulses: %0d need 65533", se_n - s0); end
    push(0); push(0);
    drain(200);
    checks += 3;
    if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: %h need ffff", err_cnt); end
    if (se_n - s0 != 65535) begin errors++; $display("FAIL sat_more: %0d need 65535", se_n - s0); end
    if (frame_cnt !== 16'd4) begin errors++; $display("FAIL sat_fcnt: %0d need 4", frame_cnt); end
  endtask

  task automatic test_clr_collide;
    int n;
    push_range(1, 1023);
    n = 0;
    while (!(bvld && fifo_dout[15:6] == 10'd1023) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    checks += 3;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL clr_done: %b need 1", frame_done); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL clr_fcnt: %0d need 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_ecnt: %0d need 0", err_cnt); end
    drain(200);
  endtask

  task automatic test_reset_mid;
    int w0, s0, n;
    push_range(0, 3);
    w0 = wr_n; s0 = se_n; n = 0;
    while (!bvld && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain(200);
    checks += 4;
    if (wr_n != w0) begin errors++; $display("FAIL rm_writes: %0d need 0", wr_n - w0); end
    if (se_n != s0) begin errors++; $display("FAIL rm_err: %0d need 0", se_n - s0); end
    if (synced !== 1'b0) begin errors++; $display("FAIL rm_synced: %b need 0", synced); end
    if (ord_n != 0) begin errors++; $display("FAIL rm_order: %0d need 0", ord_n); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_full_frame;
    test_sync_search;
    test_seq_error;
    test_restart;
    test_gap;
    test_err_sat;
    test_clr_collide;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
